// File: rtl/mem_store_queue_p_pkg.sv
// Shared defaults and helpers for the posted-write store queue.
package msq_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 128;

  // Circular-buffer pointer advance; wraps to zero at depth.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/mem_store_queue_p_if.sv
// Core-side store bus and target-side drain port of the store queue.
interface mem_store_queue_p_if
  import msq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              can_write;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  modport master (
    output wr_en, wr_addr, wr_data, can_write,
    input  out_addr, out_data, out_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, can_write,
    output out_addr, out_data, out_valid
  );
endinterface

// File: rtl/mem_store_queue_p_youngest_match.sv
// Picks the youngest matching queue slot: rotate by rd_ptr, highest age wins.
module msq_youngest_match #(
  parameter  int unsigned DEPTH = 128,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic             hit,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] pos;

  // Later (younger) ages overwrite earlier ones.
  always_comb begin
    hit = 1'b0;
    idx = rd_ptr;
    pos = rd_ptr;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pos = rd_ptr + PTR_W'(k);
      if (match[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/mem_store_queue_p.sv
// Posted-write store FIFO with store-to-load forwarding, occupancy and sticky overflow.
module mem_store_queue_p
  import msq_pkg::*;
#(
  parameter  int unsigned DATA_W    = DATA_W_DEF,
  parameter  int unsigned ADDR_W    = ADDR_W_DEF,
  parameter  int unsigned DEPTH     = DEPTH_DEF,
  parameter  int unsigned EDGE_MODE = 1,
  parameter  int unsigned AFULL_LVL = DEPTH - 4,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_store_queue_p_if.slave  bus,
  output logic                full,
  output logic                empty,
  output logic                afull,
  output logic [CNT_W-1:0]    count,
  output logic                overflow,
  input  logic                ovf_clr,
  input  logic [ADDR_W-1:0]   lk_addr,
  output logic                lk_hit,
  output logic [DATA_W-1:0]   lk_data
);

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } lk_res_t;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              wr_en_q;
  lk_res_t           lk_q;
  lk_res_t           lk_next;

  logic              req;
  logic              pop;
  logic              push;
  logic              drop;
  logic [DEPTH-1:0]  match;
  logic              q_hit;
  logic [PTR_W-1:0]  q_idx;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign afull = (count >= CNT_W'(AFULL_LVL));

  assign req  = (EDGE_MODE != 0) ? (bus.wr_en && !wr_en_q) : bus.wr_en;
  assign pop  = bus.can_write && !empty;
  assign push = req && (!full || pop);
  assign drop = req && full && !pop;

  assign bus.out_valid = pop;
  assign bus.out_addr  = mem_addr[rd_ptr];
  assign bus.out_data  = mem_data[rd_ptr];

  assign lk_hit  = lk_q.hit;
  assign lk_data = lk_q.data;

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign match[g] = valid[g] && (mem_addr[g] == lk_addr);
  end

  msq_youngest_match #(.DEPTH(DEPTH)) u_match (
    .match  (match),
    .rd_ptr (rd_ptr),
    .hit    (q_hit),
    .idx    (q_idx)
  );

  // The store entering this cycle is younger than anything already queued.
  always_comb begin
    lk_next = '0;
    if (push && (bus.wr_addr == lk_addr)) begin
      lk_next.hit  = 1'b1;
      lk_next.data = bus.wr_data;
    end else if (q_hit) begin
      lk_next.hit  = 1'b1;
      lk_next.data = mem_data[q_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      valid    <= '0;
      wr_en_q  <= 1'b0;
      overflow <= 1'b0;
      lk_q     <= '0;
    end else begin
      wr_en_q <= bus.wr_en;
      lk_q    <= lk_next;
      if (pop) begin
        rd_ptr        <= PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
        valid[rd_ptr] <= 1'b0;
      end
      // Set after clear: a full queue popping and pushing reuses the same slot.
      if (push) begin
        wr_ptr        <= PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
        valid[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Payload storage carries no reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= bus.wr_addr;
      mem_data[wr_ptr] <= bus.wr_data;
    end
  end

endmodule

// File: tb/tb_mem_store_queue_p.sv
// Self-checking bench for mem_store_queue_p (DEPTH=4, AFULL_LVL=3, edge-triggered enqueue).
module tb_mem_store_queue_p;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFULL = 3;

  logic        clk;
  logic        rst_n;
  logic        full, empty, afull, overflow, ovf_clr, lk_hit;
  logic [2:0]  count;
  logic [15:0] lk_addr;
  logic [7:0]  lk_data;

  int n_pass;
  int n_total;

  mem_store_queue_p_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_store_queue_p #(
    .DATA_W(8), .ADDR_W(16), .DEPTH(DEPTH), .EDGE_MODE(1), .AFULL_LVL(AFULL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .full(full), .empty(empty), .afull(afull), .count(count),
    .overflow(overflow), .ovf_clr(ovf_clr),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue contents in age order plus registered side state
  logic [15:0] mq_a[$];
  logic [7:0]  mq_d[$];
  bit          m_wr_q, m_ovf, m_hit;
  logic [7:0]  m_data;

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
    logic        cw;
    logic        clr;
    logic [15:0] lk;
    int          cnt;
    logic        ov;
    logic [15:0] oa;
    logic [7:0]  od;
    logic        ovf;
    logic        hit;
    logic [7:0]  ld;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    mq_a.delete(); mq_d.delete();
    m_wr_q = 0; m_ovf = 0; m_hit = 0; m_data = '0;
  endtask

  task automatic model_step();
    bit req, pop, push, full_m, nh;
    logic [7:0] nd;
    int n;
    n      = mq_d.size();
    req    = bus.wr_en && !m_wr_q;
    pop    = bus.can_write && (n > 0);
    full_m = (n == DEPTH);
    push   = req && (!full_m || pop);
    nh = 0; nd = '0;
    if (push && bus.wr_addr == lk_addr) begin
      nh = 1; nd = bus.wr_data;
    end else begin
      for (int k = n - 1; k >= 0; k--)
        if (!nh && mq_a[k] == lk_addr) begin nh = 1; nd = mq_d[k]; end
    end
    if (req && full_m && !pop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (pop) begin void'(mq_a.pop_front()); void'(mq_d.pop_front()); end
    if (push) begin mq_a.push_back(bus.wr_addr); mq_d.push_back(bus.wr_data); end
    m_wr_q = bus.wr_en; m_hit = nh; m_data = nd;
  endtask

  task automatic check_model();
    int n;
    n = mq_d.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("afull", 32'(afull), 32'(n >= AFULL));
    chk("out_valid", 32'(bus.out_valid), 32'(bus.can_write && n > 0));
    if (n > 0) begin
      chk("out_addr", 32'(bus.out_addr), 32'(mq_a[0]));
      chk("out_data", 32'(bus.out_data), 32'(mq_d[0]));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("lk_hit", 32'(lk_hit), 32'(m_hit));
    chk("lk_data", 32'(lk_data), 32'(m_data));
  endtask

  task automatic set_in(input logic we, input logic [15:0] a, input logic [7:0] d,
                        input logic cw, input logic clr, input logic [15:0] lk);
    bus.wr_en = we; bus.wr_addr = a; bus.wr_data = d;
    bus.can_write = cw; ovf_clr = clr; lk_addr = lk;
  endtask

  task automatic cycle();
    @(negedge clk); check_model();
    @(posedge clk); model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, '0, '0, 0, 0, 16'hFFFF);
    #1; model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic addv(input logic we, input logic [15:0] a, input logic [7:0] d, input logic cw,
                      input logic clr, input logic [15:0] lk, input int cnt, input logic ov,
                      input logic [15:0] oa, input logic [7:0] od, input logic ovf,
                      input logic hit, input logic [7:0] ld);
    vec_t v;
    v.we = we; v.a = a; v.d = d; v.cw = cw; v.clr = clr; v.lk = lk;
    v.cnt = cnt; v.ov = ov; v.oa = oa; v.od = od; v.ovf = ovf; v.hit = hit; v.ld = ld;
    vt.push_back(v);
  endtask

  int exp_next;

  // Pop-order and occupancy-bound check for the wrap sequence
  task automatic tick_order();
    @(negedge clk);
    check_model();
    if (bus.can_write && mq_d.size() > 0) begin
      chk("wrap_order", 32'(bus.out_data), 32'(exp_next));
      exp_next++;
    end
    chk("wrap_cnt_le4", 32'(count <= 3'(DEPTH)), 32'd1);
    @(posedge clk); model_step();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0;
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(afull), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_lk_hit", 32'(lk_hit), 32'd0);

    // we, addr, data, cw, clr, lk  |  cnt, ov, oa, od, ovf, hit, ld
    addv(1, 16'h2000, 8'h55, 0, 0, 16'hFFFF,  0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) addv(1, 16'h2000, 8'h55, 0, 0, 16'hFFFF, 1, 0, 0, 0, 0, 0, 0);
    addv(0, 16'h2000, 8'h55, 1, 0, 16'hFFFF,  1, 1, 16'h2000, 8'h55, 0, 0, 0);
    addv(0, 16'h0000, 8'h00, 0, 0, 16'hFFFF,  0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      addv(1, 16'h3000 + 16'(i), 8'h10 + 8'(i), 0, 0, 16'hFFFF, i, 0, 0, 0, 0, 0, 0);
      addv(0, 16'h0000, 8'h00, 0, 0, 16'hFFFF, i + 1, 0, 0, 0, 0, 0, 0);
    end
    addv(1, 16'h3004, 8'h14, 0, 0, 16'hFFFF,  4, 0, 0, 0, 0, 0, 0);
    addv(0, 16'h0000, 8'h00, 0, 0, 16'hFFFF,  4, 0, 0, 0, 1, 0, 0);
    addv(0, 16'h0000, 8'h00, 0, 1, 16'hFFFF,  4, 0, 0, 0, 1, 0, 0);
    addv(0, 16'h0000, 8'h00, 0, 0, 16'hFFFF,  4, 0, 0, 0, 0, 0, 0);
    addv(1, 16'h3099, 8'h99, 1, 0, 16'hFFFF,  4, 1, 16'h3000, 8'h10, 0, 0, 0);
    addv(0, 16'h0000, 8'h00, 1, 0, 16'hFFFF,  4, 1, 16'h3001, 8'h11, 0, 0, 0);
    addv(0, 16'h0000, 8'h00, 1, 0, 16'hFFFF,  3, 1, 16'h3002, 8'h12, 0, 0, 0);
    addv(0, 16'h0000, 8'h00, 1, 0, 16'hFFFF,  2, 1, 16'h3003, 8'h13, 0, 0, 0);
    addv(0, 16'h0000, 8'h00, 1, 0, 16'hFFFF,  1, 1, 16'h3099, 8'h99, 0, 0, 0);
    addv(0, 16'h0000, 8'h00, 0, 0, 16'hFFFF,  0, 0, 0, 0, 0, 0, 0);
    addv(1, 16'h0100, 8'hAA, 0, 0, 16'h0100,  0, 0, 0, 0, 0, 0, 8'h00);
    addv(0, 16'h0000, 8'h00, 0, 0, 16'h0100,  1, 0, 0, 0, 0, 1, 8'hAA);
    addv(1, 16'h0100, 8'hBB, 0, 0, 16'h0100,  1, 0, 0, 0, 0, 1, 8'hAA);
    addv(0, 16'h0000, 8'h00, 0, 0, 16'h0100,  2, 0, 0, 0, 0, 1, 8'hBB);
    addv(0, 16'h0000, 8'h00, 0, 0, 16'h0200,  2, 0, 0, 0, 0, 1, 8'hBB);
    addv(0, 16'h0000, 8'h00, 0, 0, 16'h0200,  2, 0, 0, 0, 0, 0, 8'h00);

    foreach (vt[i]) begin
      set_in(vt[i].we, vt[i].a, vt[i].d, vt[i].cw, vt[i].clr, vt[i].lk);
      @(negedge clk);
      check_model();
      chk("vec_count", 32'(count), 32'(vt[i].cnt));
      chk("vec_out_valid", 32'(bus.out_valid), 32'(vt[i].ov));
      if (vt[i].ov) begin
        chk("vec_out_addr", 32'(bus.out_addr), 32'(vt[i].oa));
        chk("vec_out_data", 32'(bus.out_data), 32'(vt[i].od));
      end
      chk("vec_overflow", 32'(overflow), 32'(vt[i].ovf));
      chk("vec_lk_hit", 32'(lk_hit), 32'(vt[i].hit));
      chk("vec_lk_data", 32'(lk_data), 32'(vt[i].ld));
      @(posedge clk); model_step();
      #1;
    end

    // Pointer wrap with lagging drain
    do_reset();
    exp_next = 0;
    for (int i = 0; i < 10; i++) begin
      set_in(1, 16'h4000 + 16'(i), 8'(i), 0, 0, 16'h4009);
      tick_order();
      set_in(0, 16'h0000, 8'h00, (i % 3) != 0, 0, 16'h4009);
      if (i == 9) begin
        @(negedge clk);
        chk("wrap_fwd_hit", 32'(lk_hit), 32'd1);
        chk("wrap_fwd_data", 32'(lk_data), 32'd9);
      end
      tick_order();
    end
    set_in(0, 16'h0000, 8'h00, 1, 0, 16'h4009);
    for (int n = 0; n < 20 && mq_d.size() > 0; n++) tick_order();
    chk("wrap_drained", 32'(empty), 32'd1);

    // Reset while draining
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 16'h5000 + 16'(i), 8'h60 + 8'(i), 0, 0, 16'h5001);
      cycle();
      set_in(0, 16'h0000, 8'h00, 0, 0, 16'h5001);
      cycle();
    end
    set_in(0, 16'h0000, 8'h00, 1, 0, 16'h5001);
    cycle();
    chk("mid_count", 32'(count), 32'd3);
    chk("mid_lk_hit", 32'(lk_hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_lk_hit", 32'(lk_hit), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_in(1, 16'h6000, 8'h77, 0, 0, 16'hFFFF);
    cycle();
    set_in(0, 16'h0000, 8'h00, 1, 0, 16'hFFFF);
    @(negedge clk);
    check_model();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_addr", 32'(bus.out_addr), 32'h6000);
    chk("post_rst_data", 32'(bus.out_data), 32'h77);
    @(posedge clk); model_step();
    #1;

    // Randomised traffic over a small address set so forwarding hits often
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 6, 16'h7000 + 16'($urandom_range(0, 7)), 8'($urandom),
             $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0,
             16'h7000 + 16'($urandom_range(0, 7)));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
